// File: rtl/hazard_ctrl.sv
// Purpose: in-order pipeline hazard unit (load-use stall, branch flush, memory-wait freeze, EX operand forwarding).
// Latency: control and forwarding outputs are combinational from inputs and registered stage records; records advance 1 cycle/edge.
// Backpressure: mem_ready=0 on a load in MEM freezes every stage; a load-use hazard holds PC/IF-ID for exactly one cycle.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LU_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } ex_rec_t;

    // Later stages only need the destination side of the record.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } mem_rec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } wb_rec_t;

    ex_rec_t     r_ex;
    mem_rec_t    r_mem;
    wb_rec_t     r_wb;
    logic [1:0]  r_state;
    logic [15:0] r_stall_cnt;

    logic [1:0]  w_state_nxt;
    logic        w_br;
    logic        w_mem_wait;
    logic        w_load_use;

    assign w_br       = br_taken & rstn;
    assign w_mem_wait = rstn & r_mem.valid & r_mem.memread & ~mem_ready;
    // EX is always a bubble in LU_STALL, so a fresh load-use cannot arise there.
    assign w_load_use = id_valid & r_ex.valid & r_ex.memread & (r_ex.rd != 5'd0)
                      & ((r_ex.rd == id_rs1) | (r_ex.rd == id_rs2))
                      & (r_state != LU_STALL);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        w_state_nxt = RUN;
        if (w_mem_wait) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            w_state_nxt = MEM_WAIT;
        end else if (w_br) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            w_state_nxt = LU_STALL;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (r_mem.valid && r_mem.regwrite && (r_mem.rd != 5'd0) && (r_mem.rd == r_ex.rs1))
            fwd_a = 2'b10;
        else if (r_wb.valid && r_wb.regwrite && (r_wb.rd != 5'd0) && (r_wb.rd == r_ex.rs1))
            fwd_a = 2'b01;
        if (r_mem.valid && r_mem.regwrite && (r_mem.rd != 5'd0) && (r_mem.rd == r_ex.rs2))
            fwd_b = 2'b10;
        else if (r_wb.valid && r_wb.regwrite && (r_wb.rd != 5'd0) && (r_wb.rd == r_ex.rs2))
            fwd_b = 2'b01;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= RUN;
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!pc_write && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (!pipe_freeze) begin
                r_wb.valid     <= r_mem.valid;
                r_wb.rd        <= r_mem.rd;
                r_wb.regwrite  <= r_mem.regwrite;
                r_mem.valid    <= r_ex.valid;
                r_mem.rd       <= r_ex.rd;
                r_mem.regwrite <= r_ex.regwrite;
                r_mem.memread  <= r_ex.memread;
                if (idex_bubble || !id_valid) begin
                    r_ex <= '0;
                end else begin
                    r_ex.valid    <= 1'b1;
                    r_ex.rs1      <= id_rs1;
                    r_ex.rs2      <= id_rs2;
                    r_ex.rd       <= id_rd;
                    r_ex.regwrite <= id_regwrite;
                    r_ex.memread  <= id_memread;
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one task per scenario, each with its own inline checks.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        id_memread = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad = 0;

    hazard_ctrl dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .br_taken(br_taken), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        br_taken = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; br_taken = 1'b1; mem_ready = 1'b0;
        set_id(1, 2, 3, 2, 1, 1);
        #2;
        total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL rst_pc_write got=%b exp=1", pc_write); end
        total++; if (ifid_write !== 1'b1) begin bad++; $display("FAIL rst_ifid_write got=%b exp=1", ifid_write); end
        total++; if (ifid_flush !== 1'b0) begin bad++; $display("FAIL rst_ifid_flush got=%b exp=0", ifid_flush); end
        total++; if (idex_bubble !== 1'b0) begin bad++; $display("FAIL rst_idex_bubble got=%b exp=0", idex_bubble); end
        total++; if (pipe_freeze !== 1'b0) begin bad++; $display("FAIL rst_pipe_freeze got=%b exp=0", pipe_freeze); end
        total++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL rst_fwd got=%b/%b exp=00/00", fwd_a, fwd_b); end
        tick;
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
        total++; if (pipe_freeze !== 1'b0 || ifid_flush !== 1'b0) begin bad++; $display("FAIL rst_held got freeze=%b flush=%b exp=0/0", pipe_freeze, ifid_flush); end
        rstn = 1'b1; br_taken = 1'b0; mem_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fwd_mem;
        do_reset;
        set_id(1, 0, 0, 1, 1, 0); tick;
        set_id(1, 1, 5, 4, 1, 0); #1;
        total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL fm_no_stall got=%b exp=1", pc_write); end
        tick;
        set_id(0, 0, 0, 0, 0, 0); #1;
        total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL fm_fwd_a got=%b exp=10", fwd_a); end
        total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL fm_fwd_b got=%b exp=00", fwd_b); end
    endtask

    task automatic test_fwd_prio;
        do_reset;
        set_id(1, 0, 0, 3, 1, 0); tick;
        set_id(1, 0, 0, 3, 1, 0); tick;
        set_id(1, 0, 3, 7, 1, 0); tick;
        set_id(0, 0, 0, 0, 0, 0); #1;
        total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL fp_mem_prio got=%b exp=10", fwd_b); end
        total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL fp_fwd_a got=%b exp=00", fwd_a); end
        do_reset;
        set_id(1, 0, 0, 3, 1, 0); tick;
        set_id(0, 0, 0, 0, 0, 0); tick;
        set_id(1, 0, 3, 7, 1, 0); tick;
        set_id(0, 0, 0, 0, 0, 0); #1;
        total++; if (fwd_b !== 2'b01) begin bad++; $display("FAIL fp_wb_only got=%b exp=01", fwd_b); end
    endtask

    task automatic test_load_use;
        do_reset;
        set_id(1, 7, 0, 2, 1, 1); tick;
        set_id(1, 2, 9, 5, 1, 0); #1;
        total++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin bad++; $display("FAIL lu_hold got pc=%b ifid=%b exp=0/0", pc_write, ifid_write); end
        total++; if (idex_bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b exp=1", idex_bubble); end
        total++; if (ifid_flush !== 1'b0 || pipe_freeze !== 1'b0) begin bad++; $display("FAIL lu_flush_freeze got=%b/%b exp=0/0", ifid_flush, pipe_freeze); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL lu_cnt_before got=%0d exp=0", stall_cnt); end
        tick;
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_after got=%0d exp=1", stall_cnt); end
        total++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin bad++; $display("FAIL lu_resume got pc=%b bub=%b exp=1/0", pc_write, idex_bubble); end
        tick;
        set_id(0, 0, 0, 0, 0, 0); #1;
        total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL lu_fwd_a got=%b exp=01", fwd_a); end
        total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL lu_fwd_b got=%b exp=00", fwd_b); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_final got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_br_lu;
        do_reset;
        set_id(1, 7, 0, 2, 1, 1); tick;
        set_id(1, 2, 9, 5, 1, 0); br_taken = 1'b1; #1;
        total++; if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1) begin bad++; $display("FAIL br_flush got flush=%b bub=%b exp=1/1", ifid_flush, idex_bubble); end
        total++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin bad++; $display("FAIL br_write got pc=%b ifid=%b exp=1/1", pc_write, ifid_write); end
        tick;
        br_taken = 1'b0; set_id(0, 0, 0, 0, 0, 0); #1;
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL br_cnt got=%0d exp=0", stall_cnt); end
        total++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin bad++; $display("FAIL br_after got pc=%b bub=%b exp=1/0", pc_write, idex_bubble); end
    endtask

    task automatic test_mem_wait;
        do_reset;
        set_id(1, 0, 0, 4, 1, 0); tick;
        set_id(1, 0, 0, 6, 1, 1); tick;
        set_id(1, 4, 0, 8, 1, 0); tick;
        set_id(1, 8, 6, 9, 1, 0); mem_ready = 1'b0; #1;
        total++; if (pipe_freeze !== 1'b1) begin bad++; $display("FAIL mw_freeze0 got=%b exp=1", pipe_freeze); end
        total++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin bad++; $display("FAIL mw_hold got pc=%b ifid=%b exp=0/0", pc_write, ifid_write); end
        total++; if (ifid_flush !== 1'b0 || idex_bubble !== 1'b0) begin bad++; $display("FAIL mw_flush_bub got=%b/%b exp=0/0", ifid_flush, idex_bubble); end
        total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL mw_fwd_a0 got=%b exp=01", fwd_a); end
        for (int i = 1; i <= 2; i++) begin
            tick;
            total++; if (pipe_freeze !== 1'b1) begin bad++; $display("FAIL mw_freeze%0d got=%b exp=1", i, pipe_freeze); end
            total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL mw_frozen_fwd%0d got=%b exp=01", i, fwd_a); end
            total++; if (stall_cnt !== 16'(i)) begin bad++; $display("FAIL mw_cnt%0d got=%0d exp=%0d", i, stall_cnt, i); end
        end
        tick;
        mem_ready = 1'b1; #1;
        total++; if (pipe_freeze !== 1'b0 || pc_write !== 1'b1) begin bad++; $display("FAIL mw_release got freeze=%b pc=%b exp=0/1", pipe_freeze, pc_write); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL mw_cnt3 got=%0d exp=3", stall_cnt); end
        tick;
        set_id(0, 0, 0, 0, 0, 0); #1;
        total++; if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin bad++; $display("FAIL mw_advance got=%b/%b exp=10/01", fwd_a, fwd_b); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL mw_cnt_final got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_zero_and_reset;
        do_reset;
        set_id(1, 0, 0, 0, 1, 1); tick;
        set_id(1, 0, 0, 3, 1, 0); #1;
        total++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin bad++; $display("FAIL z_no_stall got pc=%b bub=%b exp=1/0", pc_write, idex_bubble); end
        tick;
        set_id(0, 0, 0, 0, 0, 0); #1;
        total++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL z_no_fwd got=%b/%b exp=00/00", fwd_a, fwd_b); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL z_cnt got=%0d exp=0", stall_cnt); end
        mem_ready = 1'b0; #1;
        total++; if (pipe_freeze !== 1'b1) begin bad++; $display("FAIL z_wait got=%b exp=1", pipe_freeze); end
        tick;
        total++; if (stall_cnt !== 16'd1 || pipe_freeze !== 1'b1) begin bad++; $display("FAIL z_wait_held got cnt=%0d freeze=%b exp=1/1", stall_cnt, pipe_freeze); end
        #2;
        rstn = 1'b0; br_taken = 1'b1; #1;
        total++; if (pipe_freeze !== 1'b0 || pc_write !== 1'b1 || ifid_write !== 1'b1) begin bad++; $display("FAIL zr_ctrl got freeze=%b pc=%b ifid=%b exp=0/1/1", pipe_freeze, pc_write, ifid_write); end
        total++; if (ifid_flush !== 1'b0 || idex_bubble !== 1'b0) begin bad++; $display("FAIL zr_flush got=%b/%b exp=0/0", ifid_flush, idex_bubble); end
        total++; if (stall_cnt !== 16'd0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL zr_state got cnt=%0d fwd=%b/%b exp=0/00/00", stall_cnt, fwd_a, fwd_b); end
        @(posedge clk); #1;
        rstn = 1'b1; br_taken = 1'b0; #1;
        total++; if (pipe_freeze !== 1'b0 || pc_write !== 1'b1) begin bad++; $display("FAIL zr_release got freeze=%b pc=%b exp=0/1", pipe_freeze, pc_write); end
        tick;
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL zr_cnt_after got=%0d exp=0", stall_cnt); end
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_fwd_mem;
        test_fwd_prio;
        test_load_use;
        test_br_lu;
        test_mem_wait;
        test_zero_and_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: id_valid  input  1  instruction present in ID stage.
REQ-004 SHALL have ports: id_rs1, id_rs2, id_rd  input  5 each  ID-stage source/destination register numbers.
REQ-005 SHALL have ports: id_regwrite, id_memread  input  1 each  ID instruction writes a register / is a load.
REQ-006 SHALL have port: br_taken  input  1  branch resolved taken by the instruction currently in EX.
REQ-007 SHALL have port: mem_ready  input  1  data memory completes the access held in MEM this cycle.
REQ-008 SHALL have ports: pc_write, ifid_write  output  1 each  enable PC and IF/ID register updates.
REQ-009 SHALL have ports: ifid_flush, idex_bubble  output  1 each  clear IF/ID; load NOP into ID/EX.
REQ-010 SHALL have port: pipe_freeze  output  1  hold every pipeline register.
REQ-011 SHALL have ports: fwd_a, fwd_b  output  2 each  ALU operand select for the EX instruction: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-012 SHALL have port: stall_cnt  output  16  saturating count of cycles with pc_write=0.

Function
REQ-013 SHALL keep internal stage records EX, MEM, WB, each holding {valid, rs1, rs2, rd, regwrite, memread}; only EX uses rs1/rs2.
REQ-014 SHALL advance records on each edge when pipe_freeze=0: WB<=MEM, MEM<=EX, EX<=ID fields, or all-zero when idex_bubble=1 or id_valid=0.
REQ-015 SHALL hold all records unchanged on any edge with pipe_freeze=1.
REQ-016 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT; reset state RUN.
REQ-017 SHALL detect load-use: id_valid & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs1 | EX.rd==id_rs2).
REQ-018 SHALL detect mem-wait: MEM.valid & MEM.memread & !mem_ready.
REQ-019 SHALL apply event priority mem-wait > br_taken > load-use, evaluated combinationally each cycle.
REQ-020 SHALL, on mem-wait: pipe_freeze=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0; next state MEM_WAIT; stay until mem_ready=1, then RUN.
REQ-021 SHALL, on br_taken without mem-wait: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; state stays RUN; a coincident load-use is discarded.
REQ-022 SHALL, on load-use only: pc_write=0, ifid_write=0, idex_bubble=1; next state LU_STALL for exactly one cycle, then RUN.
REQ-023 SHALL in LU_STALL, absent new events, drive pc_write=1, ifid_write=1, idex_bubble=0 (hazard resolved via MEM/WB forwarding).
REQ-024 SHALL otherwise drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
REQ-025 SHALL compute fwd_a from registered EX.rs1: 10 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1; else 01 if same test on WB; else 00.
REQ-026 SHALL compute fwd_b identically against EX.rs2; code 11 SHALL never be produced.
REQ-027 SHALL increment stall_cnt on each edge where pc_write=0, saturating at 16'hFFFF with no wrap.
REQ-028 SHALL never forward or stall on register 0.

Reset
REQ-029 SHALL, while rstn=0, clear all stage records, set FSM to RUN, set stall_cnt=0, and drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0, fwd_a=fwd_b=00.
REQ-030 SHALL, on reset asserted mid-stall or mid-MEM_WAIT, abandon the sequence immediately and resume from RUN after release.

Verification
REQ-031 SHALL cover: EX record {rd=1, regwrite=1} advanced to MEM, next EX rs1=1 -> fwd_a=10, fwd_b=00.
REQ-032 SHALL cover: MEM and WB both write rd=3, EX rs2=3 -> fwd_b=10 (MEM priority); WB only -> fwd_b=01.
REQ-033 SHALL cover: load rd=2 in EX, ID rs1=2 -> one cycle pc_write=0, idex_bubble=1, stall_cnt 0->1; next cycle fwd_a=01.
REQ-034 SHALL cover: load-use plus br_taken in same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, stall_cnt unchanged.
REQ-035 SHALL cover: load in MEM, mem_ready=0 for 3 cycles -> pipe_freeze=1 for 3 cycles, records frozen, stall_cnt=3, release on mem_ready=1.
REQ-036 SHALL cover: ID rs1=0 against load rd=0 -> no stall, fwd_a=00; rstn pulse during MEM_WAIT -> all outputs at reset values.
